// File: rtl/cpu_pkg.sv
// Shared CPU memory-map constants and the PC unit state type.
// Reused by the instruction memory, CP0 and next-PC logic.
package cpu_pkg;

  localparam logic [31:0] RESET_VEC  = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC    = 32'h0000_4180;
  localparam int unsigned IM_DEPTH   = 4096;
  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic {
    PC_RUN  = 1'b0,
    PC_HOLD = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_unit.sv
// IF-stage program counter: sequential fetch, stall with captured redirect,
// exception entry / eret return, and a fetch-address-error flag.
module pc_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VEC = WIDTH'(cpu_pkg::RESET_VEC),
  parameter logic [WIDTH-1:0]  EXC_VEC   = WIDTH'(cpu_pkg::EXC_VEC),
  parameter int unsigned       IM_DEPTH  = cpu_pkg::IM_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] target,
  input  logic             exc_req,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             adel,
  output logic             pending
);

  // One extra bit keeps the upper bound from wrapping when the window
  // touches the top of the address space.
  localparam logic [WIDTH:0] RANGE_LO = {1'b0, RESET_VEC};
  localparam logic [WIDTH:0] RANGE_HI = RANGE_LO + (WIDTH+1)'(WORD_BYTES * IM_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;
  pc_state_e        state_q, state_d;
  logic [WIDTH:0]   pc_ext;

  assign pc_plus4 = pc_q + WIDTH'(WORD_BYTES);

  always_comb begin
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    state_d       = state_q;
    if (exc_req) begin
      pc_d    = EXC_VEC;
      state_d = PC_RUN;
    end else if (eret) begin
      pc_d    = epc;
      state_d = PC_RUN;
    end else if (stall) begin
      if (redirect) begin
        pend_target_d = target;
        state_d       = PC_HOLD;
      end
    end else if (redirect) begin
      pc_d    = target;
      state_d = PC_RUN;
    end else if (state_q == PC_HOLD) begin
      pc_d    = pend_target_q;
      state_d = PC_RUN;
    end else begin
      pc_d = pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_VEC;
      pend_target_q <= '0;
      state_q       <= PC_RUN;
    end else begin
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      state_q       <= state_d;
    end
  end

  assign pc_ext  = {1'b0, pc_q};
  assign adel    = (pc_q[1:0] != 2'b00) || (pc_ext < RANGE_LO) || (pc_ext >= RANGE_HI);
  assign pc      = pc_q;
  assign pending = (state_q == PC_HOLD);

endmodule

// File: tb/tb_pc_unit.sv
// Randomized bench for pc_unit: a 32-bit instance driven against a
// behavioural model, plus a 16-bit instance that free-runs across the wrap.
module tb_pc_unit;

  localparam longint unsigned RV     = 64'h3000;
  localparam longint unsigned EV     = 64'h4180;
  localparam longint unsigned DEPTH  = 4096;
  localparam longint unsigned RV16   = 64'hFFF8;
  localparam longint unsigned EV16   = 64'h4180;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0, redirect = 1'b0, exc_req = 1'b0, eret = 1'b0;
  logic [31:0] target = '0, epc = '0;
  logic [31:0] pc, pc_plus4;
  logic        adel, pending;

  logic [15:0] pc16, pc_plus4_16;
  logic        adel16, pending16;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  longint unsigned m_pc, m_tgt, m_pc16;
  bit              m_pend;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .target(target), .exc_req(exc_req), .eret(eret), .epc(epc),
    .pc(pc), .pc_plus4(pc_plus4), .adel(adel), .pending(pending)
  );

  pc_unit #(.WIDTH(16), .RESET_VEC(16'hFFF8), .EXC_VEC(16'h4180), .IM_DEPTH(4096)) dut16 (
    .clk(clk), .reset(reset), .stall(1'b0), .redirect(1'b0),
    .target(16'h0000), .exc_req(1'b0), .eret(1'b0), .epc(16'h0000),
    .pc(pc16), .pc_plus4(pc_plus4_16), .adel(adel16), .pending(pending16)
  );

  task automatic check_eq(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit exp_adel(input longint unsigned a, input longint unsigned base);
    return (a % 4 != 0) || (a < base) || (a >= base + 4 * DEPTH);
  endfunction

  task automatic check_all(input string tag);
    check_eq({tag, ".pc"},      pc,        m_pc);
    check_eq({tag, ".pend"},    pending,   m_pend);
    check_eq({tag, ".adel"},    adel,      exp_adel(m_pc, RV));
    check_eq({tag, ".plus4"},   pc_plus4,  (m_pc + 4) & 64'hFFFF_FFFF);
    check_eq({tag, ".pc16"},    pc16,      m_pc16);
    check_eq({tag, ".adel16"},  adel16,    exp_adel(m_pc16, RV16));
  endtask

  function automatic void model_reset();
    m_pc   = RV;
    m_pend = 0;
    m_tgt  = 0;
    m_pc16 = RV16;
  endfunction

  // Starts at a negedge, ends at the following negedge.
  task automatic step(input string tag, input bit s, input bit r, input longint unsigned t,
                      input bit x, input bit e, input longint unsigned ep);
    stall = s; redirect = r; target = t[31:0]; exc_req = x; eret = e; epc = ep[31:0];
    if (x) begin
      m_pc = EV; m_pend = 0;
    end else if (e) begin
      m_pc = ep; m_pend = 0;
    end else if (s) begin
      if (r) begin
        m_tgt = t; m_pend = 1;
      end
    end else if (r) begin
      m_pc = t; m_pend = 0;
    end else if (m_pend) begin
      m_pc = m_tgt; m_pend = 0;
    end else begin
      m_pc = (m_pc + 4) & 64'hFFFF_FFFF;
    end
    m_pc16 = (m_pc16 + 4) & 64'hFFFF;
    @(posedge clk);
    #1;
    $display("step %s s=%0b r=%0b t=%0h x=%0b e=%0b epc=%0h -> pc=%0h pend=%0b adel=%0b pc16=%0h",
             tag, s, r, t, x, e, ep, pc, pending, adel, pc16);
    check_all(tag);
    @(negedge clk);
  endtask

  // Asserts reset between edges and checks it takes effect without a clock.
  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    model_reset();
    $display("async reset %s -> pc=%0h pend=%0b", tag, pc, pending);
    check_all({tag, ".imm"});
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    @(negedge clk);
    stall = 0; redirect = 0; exc_req = 0; eret = 0;
    reset = 1'b1;
  endtask

  function automatic longint unsigned rand_addr();
    longint unsigned a;
    case ($urandom_range(0, 9))
      0:       a = RV - 4;
      1:       a = RV + 4 * DEPTH - 4;
      2:       a = RV + 4 * DEPTH;
      3:       a = RV + 4 * longint'($urandom_range(0, 4095)) + longint'($urandom_range(1, 3));
      4:       a = longint'($urandom);
      default: a = RV + 4 * longint'($urandom_range(0, 4095));
    endcase
    return a & 64'hFFFF_FFFF;
  endfunction

  initial begin
    model_reset();
    @(negedge clk);
    $display("reset state pc=%0h pend=%0b adel=%0b plus4=%0h", pc, pending, adel, pc_plus4);
    check_all("reset");
    reset = 1'b1;

    // Directed sequence from the plan
    step("free1", 0, 0, 0, 0, 0, 0);
    check_eq("free1.const", pc, 64'h3004);
    check_eq("wrap16a", pc16, 64'hFFFC);
    step("free2", 0, 0, 0, 0, 0, 0);
    check_eq("wrap16b", pc16, 64'h0000);
    check_eq("wrap16_adel", adel16, 1);
    step("free3", 0, 0, 0, 0, 0, 0);
    check_eq("free3.const", pc, 64'h300C);
    step("free4", 0, 0, 0, 0, 0, 0);
    step("stall1", 1, 1, 64'h3040, 0, 0, 0);
    check_eq("hold.const", pc, 64'h3010);
    check_eq("hold.pend", pending, 1);
    step("stall2", 1, 0, 0, 0, 0, 0);
    step("release", 0, 0, 0, 0, 0, 0);
    check_eq("release.const", pc, 64'h3040);
    step("after", 0, 0, 0, 0, 0, 0);
    check_eq("after.const", pc, 64'h3044);
    step("exc", 1, 1, 64'h3100, 1, 0, 0);
    check_eq("exc.const", pc, 64'h4180);
    step("eret", 0, 0, 0, 0, 1, 64'h3022);
    check_eq("eret.adel", adel, 1);
    step("redir_oor", 0, 0 | 1, 64'h7000, 0, 0, 0);
    check_eq("oor.adel", adel, 1);
    step("redir_top", 0, 1, 64'h6FFC, 0, 0, 0);
    check_eq("top.adel", adel, 0);
    step("exc_eret", 0, 0, 0, 1, 1, 64'h3200);
    step("st_r1", 1, 1, 64'h3300, 0, 0, 0);
    step("st_r2", 1, 1, 64'h3400, 0, 0, 0);
    step("live_sup", 0, 1, 64'h3500, 0, 0, 0);
    check_eq("live_sup.const", pc, 64'h3500);
    step("st_r3", 1, 1, 64'h3600, 0, 0, 0);
    async_reset("rst_hold");
    step("post_rst", 0, 0, 0, 0, 0, 0);
    check_eq("post_rst.const", pc, 64'h3004);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit s, r, x, e;
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 3) == 0);
      x = ($urandom_range(0, 24) == 0);
      e = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 99) == 0) async_reset("rnd_rst");
      else step("rnd", s, r, rand_addr(), x, e, rand_addr());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the pipelined CPU. It replaces the plain PC register of the single-cycle datapath. It holds the fetch address and advances it by 4 each cycle. On top of that it supports:
- pipeline stall,
- branch/jump redirect, including a redirect that arrives while stalled,
- exception entry and `eret` return,
- a fetch-address error (AdEL) flag.

It sits at the IF stage and drives the instruction-memory address and the F-stage PC.

## Interface
Parameters:
- `WIDTH`, 32, address width.
- `RESET_VEC`, 32'h0000_3000, PC value after reset; also the instruction-memory base.
- `EXC_VEC`, 32'h0000_4180, exception handler entry.
- `IM_DEPTH`, 4096, instruction-memory size in words; used for the range check.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset (0 = reset).
- `stall` in 1: hold PC (IF/D interlock).
- `redirect` in 1: branch/jump taken.
- `target` in WIDTH: redirect destination.
- `exc_req` in 1: exception/interrupt entry from the M stage.
- `eret` in 1: return from exception.
- `epc` in WIDTH: return address from CP0.
- `pc` out WIDTH: current fetch address (registered).
- `pc_plus4` out WIDTH: `pc + 4`, combinational.
- `adel` out 1: fetch address error, combinational from `pc`.
- `pending` out 1: a redirect captured during stall is waiting (registered).

## Operation
Registers: `pc`, `pending`, `pend_target` (WIDTH).

Two states:
- RUN: `pending`=0.
- HOLD: `pending`=1; a captured redirect is waiting.

Next-state priority, evaluated every rising edge, highest first:
1. `exc_req`: `pc`←`EXC_VEC`; `pending`←0. Ignores `stall`.
2. `eret`: `pc`←`epc`; `pending`←0. Ignores `stall`.
3. `stall`: `pc` holds.
   - If `redirect`: `pend_target`←`target`, `pending`←1.
   - A second redirect during the same stall overwrites `pend_target`.
4. `redirect`: `pc`←`target`; `pending`←0. A live redirect supersedes a pending one.
5. `pending`: `pc`←`pend_target`; `pending`←0.
6. Otherwise `pc`←`pc + 4`, modulo 2^WIDTH; wraps without error.

`adel` = 1 when either holds:
- `pc[1:0]` ≠ 0, or
- `pc` lies outside [`RESET_VEC`, `RESET_VEC` + 4·`IM_DEPTH`).

The range compare uses WIDTH+1 bits so the upper bound cannot overflow. The unit only reports `adel`; exception handling is CP0's job. `pc` still advances normally while `adel`=1.

`target` and `epc` are loaded unchecked. Misalignment surfaces through `adel`.

## Timing
- Reset (`reset`=0, asynchronous): `pc`=`RESET_VEC`, `pending`=0, `pend_target`=0, `adel`=0, `pc_plus4`=`RESET_VEC`+4. Holds while asserted.
- Reset release: the first rising edge with `reset`=1 applies the normal rules.
- Every update lands one cycle after the request, at the next rising edge.
- A redirect captured under stall takes effect on the first edge with `stall`=0, unless a higher-priority event occurs on that edge.
- Reset mid-HOLD discards the pending redirect.
- `exc_req` together with `eret`: `exc_req` wins.
- `exc_req` with `stall` and `redirect`: `EXC_VEC` is loaded and the redirect is dropped.

## Structure
- Shared package `cpu_pkg` holds `RESET_VEC`, `EXC_VEC`, `IM_DEPTH` and the word size 4. These are reused by IM, CP0 and NPC.
- Single module, no sub-module; the HOLD logic is two registers and does not justify one.

## Test plan
- Reset then 3 free cycles: `pc` = 3000 → 3004 → 3008 → 300C; `adel`=0, `pending`=0.
- `pc`=3010, `stall`=1 for 2 cycles with `redirect`=1, `target`=3040 in the first cycle only:
  - `pc` stays 3010 and `pending`=1;
  - after `stall` drops, `pc`=3040 and `pending`=0;
  - next cycle `pc`=3044.
- `exc_req`=1 together with `stall`=1 and `redirect`=1 (`target`=3100): `pc`=4180, `pending`=0.
- `eret`=1, `epc`=3022: `pc`=3022, `adel`=1. Then redirect to 7000 with `IM_DEPTH`=4096: `pc`=7000, `adel`=1 (out of range).
- `reset` pulsed low asynchronously mid-cycle while `pending`=1: `pc`=3000 immediately, without waiting for a clock edge; `pending`=0.
- WIDTH=16, `RESET_VEC`=16'hFFF8: `pc` goes FFF8 → FFFC → 0000 and wraps.
